seq_shift_add_multiplier: RTL and testbench

//   Iterative radix-2 shift-add multiplier. Parametrised operand width.
//   Per-operation signed (two's complement) / unsigned mode.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/mult_step_adder.sv | 18 +
 rtl/seq_shift_add_multiplier.sv | 101 ++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared FSM state type and width helper for the shift-add multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..value-1; callers clamp the result to at least 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_step_adder.sv
// rtl/mult_step_adder.sv - one radix-2 step: conditionally add the multiplicand into the upper accumulator half
module mult_step_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] mag_a,
  input  logic             add_en,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] total;

  assign total = {1'b0, acc_hi} + {1'b0, (add_en ? mag_a : {WIDTH{1'b0}})};
  assign sum   = total[WIDTH-1:0];
  assign carry = total[WIDTH];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - iterative signed/unsigned shift-add multiplier with valid/ready handshakes
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               tc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 neg;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     step_sum;
  logic                 step_carry;
  logic [2*WIDTH-1:0]   acc_step;

  // Magnitude of -2^(W-1) wraps to 2^(W-1), which is still correct as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_tc);
    return (is_tc && v[WIDTH-1]) ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  mult_step_adder #(.WIDTH(WIDTH)) u_step (
    .acc_hi (acc[2*WIDTH-1:WIDTH]),
    .mag_a  (mag_a),
    .add_en (mag_b[0]),
    .sum    (step_sum),
    .carry  (step_carry)
  );

  assign acc_step  = {step_carry, step_sum, acc[WIDTH-1:1]};
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)        state_next = BUSY;
      BUSY:    if (cnt == CNT_LAST) state_next = DONE;
      DONE:    if (out_ready)       state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a <= '0;
      mag_b <= '0;
      neg   <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      p     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag_a <= magnitude(a, tc);
            mag_b <= magnitude(b, tc);
            neg   <= tc & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
          end
        end
        BUSY: begin
          acc   <= acc_step;
          mag_b <= mag_b >> 1;
          cnt   <= cnt + CNT_W'(1);
          // The product register is only touched here, so it holds through DONE and after.
          if (cnt == CNT_LAST) begin
            p <= neg ? (~acc_step + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - randomized and directed bench for seq_shift_add_multiplier
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid4 = 1'b0, in_ready4, tc4 = 1'b0, out_valid4, out_ready4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  p4;

  logic        in_valid8 = 1'b0, in_ready8, tc8 = 1'b0, out_valid8, out_ready8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .tc(tc4), .out_valid(out_valid4), .out_ready(out_ready4), .p(p4)
  );

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .tc(tc8), .out_valid(out_valid8), .out_ready(out_ready8), .p(p8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Exact product of the operands interpreted per mode, reduced mod 2^(2w).
  function automatic logic [63:0] ref_prod(input longint x, input longint y, input bit s, input int w);
    longint m;
    m = (longint'(1) << (2 * w)) - 1;
    if (s && x[w-1]) x = x - (longint'(1) << w);
    if (s && y[w-1]) y = y - (longint'(1) << w);
    return 64'((x * y) & m);
  endfunction

  task automatic wait_done4(input string tag, input logic [7:0] exp);
    int lat;
    lat = 0;
    while (!out_valid4 && lat < 16) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_p"}, 64'(p4), 64'(exp));
  endtask

  task automatic op4(input logic [3:0] ia, input logic [3:0] ib, input logic itc,
                     input logic [7:0] exp, input string tag);
    @(negedge clk);
    a4 = ia; b4 = ib; tc4 = itc; in_valid4 = 1'b1;
    check({tag, "_rdy"}, 64'(in_ready4), 64'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    check({tag, "_busy"}, 64'(in_ready4), 64'd0);
    wait_done4(tag, exp);
    @(negedge clk);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    check({tag, "_idle"}, 64'(in_ready4), 64'd1);
  endtask

  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic itc,
                     input logic [15:0] exp, input string tag);
    int lat;
    @(negedge clk);
    a8 = ia; b8 = ib; tc8 = itc; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (!out_valid8 && lat < 32) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd8);
    check({tag, "_p"}, 64'(p8), 64'(exp));
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
    end
    check({tag, "_hold"}, 64'({out_valid8, p8}), 64'({1'b1, exp}));
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rt;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready4), 64'd1);
    check("rst_out_valid", 64'(out_valid4), 64'd0);
    check("rst_p", 64'(p4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op4(4'hF, 4'hF, 1'b0, 8'hE1, "u15x15");
    op4(4'h8, 4'h8, 1'b1, 8'h40, "sminxmin");
    op4(4'hD, 4'h5, 1'b1, 8'hF1, "sm3x5");
    op4(4'h7, 4'h0, 1'b1, 8'h00, "s7x0");
    op4(4'h8, 4'hF, 1'b0, 8'h78, "u8x15");
    op4(4'h9, 4'hE, 1'b1, 8'h0E, "sm7xm2");

    // Backpressure with the next operands already waiting
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd5; tc4 = 1'b0; in_valid4 = 1'b1;
    @(posedge clk); #1;
    a4 = 4'd6; b4 = 4'd7;
    wait_done4("bp_first", 8'd15);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_stall", 64'({out_valid4, in_ready4, p4}), 64'({1'b1, 1'b0, 8'd15}));
    end
    @(negedge clk);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    check("bp_release", 64'({out_valid4, in_ready4, p4}), 64'({1'b0, 1'b1, 8'd15}));
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    check("bp_accept", 64'(in_ready4), 64'd0);
    wait_done4("bp_second", 8'd42);
    @(negedge clk);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    a4 = 4'd5; b4 = 4'd3; tc4 = 1'b0; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    #1;
    check("arst_outputs", 64'({in_ready4, out_valid4, p4}), 64'({1'b1, 1'b0, 8'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("arst_no_stale", 64'({in_ready4, out_valid4}), 64'({1'b1, 1'b0}));
    end

    op8(8'h80, 8'h80, 1'b1, 16'h4000, "w8_minmin");
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "w8_ff_ff");
    op8(8'h00, 8'h00, 1'b1, 16'h0000, "w8_zero");
    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rt = 1'($urandom_range(0, 1));
      op8(ra, rb, rt, 16'(ref_prod(longint'(ra), longint'(rb), rt, 8)), "w8_rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
